// File: rtl/pri_arb_pkg.sv
// pri_arb_pkg
// Shared constants, FSM state type and index helper for the 8-requester
// priority arbiter (pri_arbiter_8) and its combinational picker (pri_pick_8).
package pri_arb_pkg;

    localparam int unsigned NREQ  = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    // Binary index of a one-hot vector; returns 0 for an all-zero input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pri_pick_8.sv
// pri_pick_8
// Combinational priority picker. Priority descends from index `top` with
// wrap-around (top, top-1, ..., 0, 7, ...). With top=7 this is plain
// fixed priority, bit 7 highest.
// Ports:
//   req [7:0]  in   request vector
//   top [2:0]  in   highest-priority index
//   win [7:0]  out  one-hot winner (0 when no request)
//   any        out  at least one request present
module pri_pick_8
    import pri_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] top,
    output logic [NREQ-1:0]  win,
    output logic             any
);

    logic [NREQ-1:0]  rot;
    logic [NREQ-1:0]  rot_win;
    logic [IDX_W-1:0] src;

    // Rotate so that req[top] lands on bit 7, take the highest set bit,
    // then rotate the one-hot result back to the original positions.
    always_comb begin
        rot     = '0;
        rot_win = '0;
        win     = '0;
        src     = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            src    = IDX_W'(j) + top + 3'd1;
            rot[j] = req[src];
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (rot[j]) begin
                rot_win    = '0;
                rot_win[j] = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            src      = IDX_W'(j) + top + 3'd1;
            win[src] = rot_win[j];
        end
        any = |req;
    end

endmodule

// File: rtl/pri_arbiter_8.sv
// pri_arbiter_8
// Sequential 8-requester bus arbiter. Grants one requester, holds the grant
// while it keeps requesting, limits each tenure to MAX_HOLD cycles and
// inserts a one-cycle bus-turnaround gap between tenures.
// Fixed priority (bit 7 highest) by default; defining PRI_ARB_ROUND_ROBIN_EN
// adds a rotating priority pointer.
// Parameters:
//   MAX_HOLD     maximum consecutive grant cycles per tenure (1..255)
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           in   arbitration enable (gates new grants only)
//   req [7:0]    in   request vector
//   gnt [7:0]    out  one-hot grant
//   gnt_idx [2:0] out binary index of granted requester (0 when idle)
//   gnt_vld      out  grant active
//   expired      out  pulse: previous tenure ended by the hold limit
//   expired_idx [2:0] out index of the timed-out requester (0 otherwise)
module pri_arbiter_8
    import pri_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             expired,
    output logic [IDX_W-1:0] expired_idx
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    arb_state_t       state;
    logic [7:0]       hold_cnt;
    logic [NREQ-1:0]  win;
    logic             any;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] top;

    pri_pick_8 u_pick (
        .req (req),
        .top (top),
        .win (win),
        .any (any)
    );

    assign win_idx = onehot_to_idx(win);

`ifdef PRI_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] top_q;

    // The winner drops to lowest priority: the next index down becomes top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= 3'd7;
        end else if (state == IDLE && en && any) begin
            top_q <= win_idx - 3'd1;
        end
    end

    assign top = top_q;
`else
    assign top = 3'd7;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            gnt_vld     <= 1'b0;
            expired     <= 1'b0;
            expired_idx <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && any) begin
                        state    <= GRANT;
                        gnt      <= win;
                        gnt_idx  <= win_idx;
                        gnt_vld  <= 1'b1;
                        hold_cnt <= 8'd1;
                    end
                end
                GRANT: begin
                    // Release is tested first so it wins over a simultaneous timeout.
                    if (!req[gnt_idx]) begin
                        state    <= GAP;
                        gnt      <= '0;
                        gnt_idx  <= '0;
                        gnt_vld  <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_cnt >= HOLD_LIMIT) begin
                        state       <= GAP;
                        expired     <= 1'b1;
                        expired_idx <= gnt_idx;
                        gnt         <= '0;
                        gnt_idx     <= '0;
                        gnt_vld     <= 1'b0;
                        hold_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                GAP: begin
                    state       <= IDLE;
                    expired     <= 1'b0;
                    expired_idx <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pri_arbiter_8.sv
module tb_pri_arbiter_8;

    localparam int unsigned HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       expired;
    logic [2:0] expired_idx;
    logic [15:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pri_arbiter_8 #(.MAX_HOLD(HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_vld     (gnt_vld),
        .expired     (expired),
        .expired_idx (expired_idx)
    );

    assign obs = {gnt, gnt_idx, gnt_vld, expired, expired_idx};

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       ex;
        logic [2:0] eidx;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [15:0] pack(input logic [7:0] g, input int gi, input logic v,
                                         input logic e, input int ei);
        return {g, 3'(gi), v, e, 3'(ei)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    int         owner;
    int         held;
    int         gap;
    int         mtop;
    logic       mexp;
    int         meidx;
    logic [7:0] cur;

    task automatic model_reset();
        owner = -1; held = 0; gap = 0; mtop = 7; mexp = 1'b0; meidx = 0;
    endtask

    task automatic model_edge(input logic e, input logic [7:0] r);
        int found;
        if (owner >= 0) begin
            if (!r[owner]) begin
                owner = -1; gap = 1; mexp = 1'b0; meidx = 0;
            end else if (held == HOLD) begin
                meidx = owner; mexp = 1'b1; owner = -1; gap = 1;
            end else begin
                held++;
            end
        end else if (gap != 0) begin
            gap = 0; mexp = 1'b0; meidx = 0;
        end else if (e && r != 8'h00) begin
            found = -1;
            for (int p = 0; p < 8; p++) begin
                int c;
                c = (mtop - p + 8) % 8;
                if (found < 0 && r[c]) found = c;
            end
            owner = found;
            held  = 1;
`ifdef PRI_ARB_ROUND_ROBIN_EN
            mtop = (owner + 7) % 8;
`endif
        end
    endtask

    function automatic logic [15:0] model_obs();
        logic [7:0] g;
        g = 8'h00;
        if (owner >= 0) g[owner] = 1'b1;
        return pack(g, (owner >= 0) ? owner : 0, owner >= 0, mexp, mexp ? meidx : 0);
    endfunction

    initial begin
        int vcnt;
        int e;

        tbl[0]  = '{1'b1, 8'h24, 8'h20, 3'd5, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 8'h24, 8'h20, 3'd5, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 8'h24, 8'h20, 3'd5, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 8'h04, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[4]  = '{1'b1, 8'h04, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[5]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 8'h01, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[8]  = '{1'b0, 8'h01, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[9]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b0, 3'd0};
        tbl[11] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b0, 3'd0};
        tbl[12] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0};
        tbl[13] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0};

        rst = 1'b1; en = 1'b0; req = 8'h00;
        #12;
        chk("reset_state", obs, 16'h0000);
        rst = 1'b0;

        // Table: fixed-priority grant/release, idle spacing, enable gating
        for (int i = 0; i < 14; i++) begin
            en  = tbl[i].en;
            req = tbl[i].req;
            step();
            chk($sformatf("tbl%0d", i), obs,
                pack(tbl[i].gnt, tbl[i].idx, tbl[i].gnt != 8'h00, tbl[i].ex, tbl[i].eidx));
        end

        // Hold-limit timeout
        en = 1'b1; req = 8'h20; vcnt = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c <= 16) begin
                if (gnt_vld && gnt_idx == 3'd5 && !expired) vcnt++;
            end else if (c == 17) begin
                chk("timeout_gap", obs, pack(8'h00, 0, 1'b0, 1'b1, 5));
            end else if (c == 18) begin
                chk("timeout_idle", obs, 16'h0000);
            end else if (c == 19) begin
                chk("timeout_regrant", obs, pack(8'h20, 5, 1'b1, 1'b0, 0));
            end
        end
        chk("timeout_hold_cycles", vcnt, 16);
        req = 8'h00;
        step();
        step();

        // Asynchronous reset mid-tenure; pointer must return to 7
        req = 8'h08;
        step();
        chk("pre_reset_grant", obs, pack(8'h08, 3, 1'b1, 1'b0, 0));
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_clear", obs, 16'h0000);
        #2;
        rst = 1'b0;
        req = 8'h09;
        step();
        chk("post_reset_top7", obs, pack(8'h08, 3, 1'b1, 1'b0, 0));
        req = 8'h00;
        step();
        step();

`ifdef PRI_ARB_ROUND_ROBIN_EN
        rst = 1'b1; #2; rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            e = 7 - (k % 8);
            req = 8'hFF;
            step();
            chk($sformatf("rr_order%0d", k), obs, pack(8'(1 << e), e, 1'b1, 1'b0, 0));
            req = ~8'(1 << e);
            step();
            req = 8'hFF;
            step();
        end
        req = 8'h01;
        step();
        chk("rr_grant0", obs, pack(8'h01, 0, 1'b1, 1'b0, 0));
        req = 8'h00;
        step();
        step();
        req = 8'h81;
        step();
        chk("rr_wrap7", obs, pack(8'h80, 7, 1'b1, 1'b0, 0));
        req = 8'h00;
        step();
        step();
`endif

        // Randomized run against the reference model
        rst = 1'b1; #2; rst = 1'b0;
        model_reset();
        cur = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) cur = 8'($urandom);
            en  = ($urandom_range(0, 9) != 0);
            req = cur;
            @(posedge clk);
            model_edge(en, req);
            #1;
            chk($sformatf("rand%0d", n), obs, model_obs());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
